axi_w_buffer: RTL

Parametrised AXI4 W-channel buffer that decouples the master-side write data stream from a slave port in the crossbar. It has valid/ready handshakes on both sides and holds the full DEPTH entries, with no lost slot. Depth does not have to be a power of two. It tracks how many complete bursts it holds and can optionally run store-and-forward, so that a burst is released only after its WLAST beat has arrived.

---
 rtl/axi_w_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/axi_w_buffer.sv
// rtl/axi_w_buffer.sv - AXI4 W-channel beat buffer with burst counting and optional store-and-forward
module axi_w_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int STORE_FWD  = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [DATA_WIDTH-1:0] s_WDATA,
    input  logic [STRB_WIDTH-1:0] s_WSTRB,
    input  logic                  s_WLAST,
    input  logic                  s_WVALID,
    output logic                  s_WREADY,
    output logic [DATA_WIDTH-1:0] m_WDATA,
    output logic [STRB_WIDTH-1:0] m_WSTRB,
    output logic                  m_WLAST,
    output logic                  m_WVALID,
    input  logic                  m_WREADY,
    output logic [CW-1:0]         level,
    output logic [CW-1:0]         burst_cnt,
    output logic                  almost_full
);

    localparam int EW = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          push, pop, push_last, pop_last;
    logic          not_empty, full;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == DEPTH_C);
    assign s_WREADY  = !full;

    // A full buffer must release even without a WLAST, else an over-long burst deadlocks.
    assign m_WVALID  = not_empty && ((STORE_FWD == 0) || (burst_q != '0) || full);

    assign {m_WDATA, m_WSTRB, m_WLAST} = mem_q[rd_ptr_q];

    assign push        = s_WVALID && s_WREADY;
    assign pop         = m_WVALID && m_WREADY;
    assign push_last   = push && s_WLAST;
    assign pop_last    = pop && m_WLAST;
    assign level       = level_q;
    assign burst_cnt   = burst_q;
    assign almost_full = (level_q >= AF_C);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        burst_d  = burst_q;

        if (push) begin
            mem_d[wr_ptr_q] = {s_WDATA, s_WSTRB, s_WLAST};
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + CW'(1);
            2'b01:   level_d = level_q - CW'(1);
            default: level_d = level_q;
        endcase

        if (push_last && !pop_last) begin
            burst_d = burst_q + CW'(1);
        end else if (pop_last && !push_last) begin
            burst_d = burst_q - CW'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            burst_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            burst_q  <= burst_d;
        end
    end

endmodule
